rob_mc: RTL
===========

Name: rob_mc

Overview:
Parametrised reorder buffer for the out-of-order core. It sits between the decoder/dispatch, the register-status table, the reservation stations, the LSB and instruction fetch. The buffer allocates one entry per cycle and accepts WB_PORTS result writebacks per cycle. It commits up to COMMIT_W entries in order per cycle and resolves branch/JALR mispredictions at the head with a registered flush-and-redirect.

Parameters:
DEPTH, 16, entry count; power of two, ≥4
IDX_W, 4, log2(DEPTH)
WB_PORTS, 3, writeback ports (ALU, CMP/branch, LSB)
COMMIT_W, 2, max commits per cycle
XLEN, 32, data/pc width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
rdy  in  1  global enable; 0 freezes all state, outputs hold
alloc_valid  in  1  dispatch request
alloc_kind  in  3  entry kind (package enum)
alloc_rd  in  5  destination register; 0 = none
alloc_val  in  XLEN  pre-known value (LUI/AUIPC/JAL result, JALR link)
alloc_pred_taken  in  1  branch prediction
alloc_alt_pc  in  XLEN  branch: not-predicted-path pc; JALR: predicted target
alloc_ready  in  1  entry needs no writeback
alloc_idx  out  IDX_W  tag given to the allocated entry (= tail)
full  out  1  count==DEPTH
src1_idx, src2_idx  in  IDX_W  operand tag lookups
src1_ready, src2_ready  out  1  value available (including same-cycle writeback)
src1_val, src2_val  out  XLEN  value if ready, else zero-extended tag
wb_valid  in  WB_PORTS  per-port writeback strobe
wb_idx  in  WB_PORTS*IDX_W  packed tags
wb_val  in  WB_PORTS*XLEN  packed results; branch: bit0 = actual taken; JALR: target
cm_valid  out  COMMIT_W  commit slot k retires this cycle
cm_rd  out  COMMIT_W*5  destination per slot
cm_idx  out  COMMIT_W*IDX_W  tag per slot
cm_val  out  COMMIT_W*XLEN  value per slot
cm_wr  out  COMMIT_W  slot writes the register file (rd!=0, kind writes rd)
store_go  out  1  head-side store commits; LSB may perform its oldest store
redirect_valid  out  1  one-cycle registered flush pulse
redirect_pc  out  XLEN  correct fetch pc

Behaviour:
- Reset: head=tail=count=0; ready[], valid[] cleared; redirect_valid=0, redirect_pc=0. All commit outputs 0 because the buffer is empty.
- Allocation: accepted iff alloc_valid && !full && !redirect_valid. The entry is written at tail; tail wraps modulo DEPTH. No same-cycle bypass of a commit freeing space: full depends only on registered count.
- Writeback: port p sets ready and stores wb_val for branch/JALR entries, keeping the actual outcome/target. If two ports hit the same tag, the lowest port index wins. Writebacks to invalid entries are ignored.
- Operand lookup (combinational): if any wb port matches the tag this cycle, return that value as ready (lowest port first). Otherwise return stored ready/val.
- Commit (combinational from registered state): slot k is valid iff slots 0..k-1 are valid, entry head+k is valid and ready, and no earlier slot this cycle is a store, branch or JALR. Control/stores therefore retire only as the last slot. At most one store per cycle, which drives store_go=1.
- Mispredict: branch where actual taken != pred_taken, or JALR where target != alt_pc.
  - On the committing edge: redirect_valid<=1. redirect_pc<= branch ? alt_pc : target.
  - On the same edge all entries are invalidated and head=tail=count=0. Same-cycle allocations are dropped.
  - The next cycle: redirect_valid=1, buffer empty, allocation blocked. The following cycle it clears.
- count_next = count + alloc_accepted − popcount(cm_valid). Simultaneous alloc and commit at full is legal next cycle only; wrap-around of head+k is modulo DEPTH.
- rdy=0: no state change, including writebacks (producers hold).
- rst mid-operation overrides flush, alloc and commit.

Decomposition:
- Package rob_pkg: kind enum (ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI_AUIPC); helper functions writes_rd(kind) and is_ctrl(kind); localparam for the enum width.
- One sub-module rob_commit_sel: COMMIT_W-wide in-order selection chain over head-relative ready/kind bits, producing cm_valid and store_go.

Test Plan:
1. Reset, allocate 16 ALU entries without writeback → full=1 after the 16th; the 17th is not accepted; alloc_idx wraps 15→0 after commits.
2. Allocate tags 0,1,2; wb tag1=5, tag0=7 the same cycle on ports 0/1 → cm_valid=2'b11 with vals 7,5; the next cycle tag2 remains at head.
3. Write back tag 3 on port 2 while src1_idx=3 → src1_ready=1 and src1_val=wb value in the same cycle.
4. Branch at head, pred_taken=1, wb bit0=0, alt_pc=0x1004 → the next cycle redirect_valid=1, redirect_pc=0x1004, count=0; the following cycle redirect_valid=0.
5. Sequence ALU(ready), STORE, ALU(ready) at head → cycle 1: ALU+STORE commit with store_go=1; cycle 2: ALU commits.
6. JALR with alt_pc=0x2000, wb target=0x2000 → commits with cm_wr=1 and link value, and no redirect; with target 0x2010 → redirect_pc=0x2010.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer: entry kinds and their
// commit/writeback properties.
package rob_pkg;

  localparam int unsigned KIND_W = 3;

  typedef enum logic [KIND_W-1:0] {
    K_ALU       = 3'd0,
    K_LOAD      = 3'd1,
    K_STORE     = 3'd2,
    K_BRANCH    = 3'd3,
    K_JAL       = 3'd4,
    K_JALR      = 3'd5,
    K_LUI_AUIPC = 3'd6
  } kind_e;

  // Kinds whose result is written to the destination register.
  function automatic logic writes_rd(input kind_e kind);
    return (kind != K_STORE) && (kind != K_BRANCH);
  endfunction

  // Kinds that may mispredict and therefore resolve at the head.
  function automatic logic is_ctrl(input kind_e kind);
    return (kind == K_BRANCH) || (kind == K_JALR);
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// In-order commit selection over the head-relative window: a slot retires only
// if every older slot retires and none of them is a store or control entry.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int unsigned COMMIT_W = 2
) (
  input  logic                en,
  input  logic [COMMIT_W-1:0] ok,
  input  kind_e               kind [COMMIT_W],
  output logic [COMMIT_W-1:0] cm_valid,
  output logic                store_go
);

  logic go;

  always_comb begin
    cm_valid = '0;
    store_go = 1'b0;
    go       = en;
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      cm_valid[k] = go && ok[k];
      if (cm_valid[k] && (kind[k] == K_STORE)) store_go = 1'b1;
      go = cm_valid[k] && !is_ctrl(kind[k]) && (kind[k] != K_STORE);
    end
  end

endmodule

// File: rtl/rob_mc.sv
// Reorder buffer: single allocation, multi-port writeback, in-order multi-commit
// and head-resolved misprediction flush with a registered redirect.
module rob_mc
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned IDX_W    = $clog2(DEPTH),
  parameter int unsigned WB_PORTS = 3,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned XLEN     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rdy,
  input  logic                         alloc_valid,
  input  kind_e                        alloc_kind,
  input  logic [4:0]                   alloc_rd,
  input  logic [XLEN-1:0]              alloc_val,
  input  logic                         alloc_pred_taken,
  input  logic [XLEN-1:0]              alloc_alt_pc,
  input  logic                         alloc_ready,
  output logic [IDX_W-1:0]             alloc_idx,
  output logic                         full,
  input  logic [IDX_W-1:0]             src1_idx,
  input  logic [IDX_W-1:0]             src2_idx,
  output logic                         src1_ready,
  output logic                         src2_ready,
  output logic [XLEN-1:0]              src1_val,
  output logic [XLEN-1:0]              src2_val,
  input  logic [WB_PORTS-1:0]          wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
  input  logic [WB_PORTS*XLEN-1:0]     wb_val,
  output logic [COMMIT_W-1:0]          cm_valid,
  output logic [COMMIT_W*5-1:0]        cm_rd,
  output logic [COMMIT_W*IDX_W-1:0]    cm_idx,
  output logic [COMMIT_W*XLEN-1:0]     cm_val,
  output logic [COMMIT_W-1:0]          cm_wr,
  output logic                         store_go,
  output logic                         redirect_valid,
  output logic [XLEN-1:0]              redirect_pc
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [IDX_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] valid, ready, pred_q;
  kind_e            kind_q [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [XLEN-1:0]  val_q  [DEPTH];
  logic [XLEN-1:0]  alt_q  [DEPTH];
  logic [XLEN-1:0]  act_q  [DEPTH];

  logic             alloc_acc;
  logic [IDX_W-1:0] wbi [WB_PORTS];
  logic [XLEN-1:0]  wbd [WB_PORTS];
  logic [IDX_W-1:0] slot_idx  [COMMIT_W];
  kind_e            slot_kind [COMMIT_W];
  logic [COMMIT_W-1:0] slot_ok;
  logic [CNT_W-1:0] n_commit;
  logic             flush;
  logic [XLEN-1:0]  flush_pc;
  logic [IDX_W-1:0] src_i [2];
  logic             src_r [2];
  logic [XLEN-1:0]  src_v [2];

  assign full      = (count == CNT_W'(DEPTH));
  assign alloc_idx = tail;
  assign alloc_acc = rdy && alloc_valid && !full && !redirect_valid;

  always_comb begin
    for (int p = 0; p < int'(WB_PORTS); p++) begin
      wbi[p] = wb_idx[p*IDX_W +: IDX_W];
      wbd[p] = wb_val[p*XLEN +: XLEN];
    end
  end

  // Operand lookup: same-cycle writeback bypass, lowest port wins.
  always_comb begin
    src_i[0] = src1_idx;
    src_i[1] = src2_idx;
    for (int s = 0; s < 2; s++) begin
      src_r[s] = ready[src_i[s]];
      src_v[s] = val_q[src_i[s]];
      for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
        if (wb_valid[p] && (wbi[p] == src_i[s])) begin
          src_r[s] = 1'b1;
          src_v[s] = wbd[p];
        end
      end
      if (!src_r[s]) src_v[s] = XLEN'(src_i[s]);
    end
  end

  assign src1_ready = src_r[0];
  assign src1_val   = src_v[0];
  assign src2_ready = src_r[1];
  assign src2_val   = src_v[1];

  always_comb begin
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      slot_idx[k]  = head + IDX_W'(k);
      slot_ok[k]   = valid[slot_idx[k]] && ready[slot_idx[k]];
      slot_kind[k] = kind_q[slot_idx[k]];
    end
  end

  rob_commit_sel #(.COMMIT_W(COMMIT_W)) u_sel (
    .en       (rdy),
    .ok       (slot_ok),
    .kind     (slot_kind),
    .cm_valid (cm_valid),
    .store_go (store_go)
  );

  // Commit payload and misprediction detection; only the last slot can be control.
  always_comb begin
    cm_rd    = '0;
    cm_idx   = '0;
    cm_val   = '0;
    cm_wr    = '0;
    n_commit = '0;
    flush    = 1'b0;
    flush_pc = '0;
    for (int k = 0; k < int'(COMMIT_W); k++) begin
      if (cm_valid[k]) begin
        cm_rd[k*5 +: 5]          = rd_q[slot_idx[k]];
        cm_idx[k*IDX_W +: IDX_W] = slot_idx[k];
        cm_val[k*XLEN +: XLEN]   = val_q[slot_idx[k]];
        cm_wr[k]  = (rd_q[slot_idx[k]] != 5'd0) && writes_rd(slot_kind[k]);
        n_commit  = n_commit + CNT_W'(1);
        if ((slot_kind[k] == K_BRANCH) &&
            (act_q[slot_idx[k]][0] != pred_q[slot_idx[k]])) begin
          flush    = 1'b1;
          flush_pc = alt_q[slot_idx[k]];
        end
        if ((slot_kind[k] == K_JALR) &&
            (act_q[slot_idx[k]] != alt_q[slot_idx[k]])) begin
          flush    = 1'b1;
          flush_pc = act_q[slot_idx[k]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head           <= '0;
      tail           <= '0;
      count          <= '0;
      valid          <= '0;
      ready          <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else if (rdy) begin
      redirect_valid <= flush;
      if (flush) begin
        redirect_pc <= flush_pc;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        valid       <= '0;
        ready       <= '0;
      end else begin
        // Descending order so the lowest port's write lands last.
        for (int p = int'(WB_PORTS) - 1; p >= 0; p--) begin
          if (wb_valid[p] && valid[wbi[p]]) begin
            ready[wbi[p]] <= 1'b1;
            if (is_ctrl(kind_q[wbi[p]])) act_q[wbi[p]] <= wbd[p];
            else                         val_q[wbi[p]] <= wbd[p];
          end
        end
        for (int k = 0; k < int'(COMMIT_W); k++) begin
          if (cm_valid[k]) valid[slot_idx[k]] <= 1'b0;
        end
        if (alloc_acc) begin
          valid[tail]  <= 1'b1;
          ready[tail]  <= alloc_ready;
          kind_q[tail] <= alloc_kind;
          rd_q[tail]   <= alloc_rd;
          val_q[tail]  <= alloc_val;
          alt_q[tail]  <= alloc_alt_pc;
          pred_q[tail] <= alloc_pred_taken;
          tail         <= tail + IDX_W'(1);
        end
        head  <= head + IDX_W'(n_commit);
        count <= count + CNT_W'(alloc_acc) - n_commit;
      end
    end
  end

endmodule
